// File: rtl/frontend_command_definition_pkg.sv
// Shared frontend command definitions used by the command queue and the backend controller.
// Holds the command layout, data-path width and the default queue depth.
package frontend_command_definition_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_READ    = 2'd1,
    OP_WRITE   = 2'd2,
    OP_REFRESH = 2'd3
  } op_type_t;

  typedef struct packed {
    op_type_t    op_type;
    logic [2:0]  bank;
    logic [13:0] row;
    logic [9:0]  col;
  } frontend_command_t;

  localparam int FRONTEND_CMD_BITS    = $bits(frontend_command_t);
  localparam int DQ_BITS              = 8;
  localparam int FRONTEND_QUEUE_DEPTH = 8;

endpackage

// File: rtl/cmd_fifo_mem.sv
// Storage array for queued {command, write data} entries.
// Synchronous write port, asynchronous (combinational) read port.
module cmd_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset; entries are only read once the count marks them valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/frontend_cmd_queue.sv
// In-order command queue in front of the backend controller with read-credit throttling.
// Optional same-cycle empty-queue bypass is enabled by defining FRONTEND_CMD_BYPASS_EN.
module frontend_cmd_queue
  import frontend_command_definition_pkg::*;
#(
  parameter int DEPTH              = FRONTEND_QUEUE_DEPTH,
  parameter int MAX_RD_OUTSTANDING = 4
) (
  input  logic                         clk,
  input  logic                         power_on_rst_n,
  input  logic                         i_host_cmd_valid,
  output logic                         o_host_cmd_ready,
  input  logic [FRONTEND_CMD_BITS-1:0] i_host_cmd,
  input  logic [DQ_BITS*8-1:0]         i_host_write_data,
  output logic                         o_frontend_command_valid,
  input  logic                         i_backend_controller_ready,
  output logic [FRONTEND_CMD_BITS-1:0] o_frontend_command,
  output logic [DQ_BITS*8-1:0]         o_frontend_write_data,
  input  logic                         i_backend_read_data_valid,
  output logic [$clog2(DEPTH):0]       o_queue_count,
  output logic [3:0]                   o_rd_outstanding,
  output logic                         o_rd_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = DQ_BITS * 8;
  localparam int EW = FRONTEND_CMD_BITS + DW;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [3:0]    RD_LIMIT   = 4'(MAX_RD_OUTSTANDING);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [3:0]    rd_cnt;
  logic          rd_underflow;

  logic [EW-1:0]     head_entry;
  frontend_command_t head_cmd, host_cmd;
  logic [DW-1:0]     head_data;

  logic queue_empty, head_is_read, host_is_read, credit_ok, queue_valid;
  logic bypass_active, bypass_take, push, pop, issue_read, rd_dec;

  cmd_fifo_mem #(
    .DEPTH(DEPTH),
    .WIDTH(EW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({i_host_cmd, i_host_write_data}),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  assign head_cmd  = frontend_command_t'(head_entry[EW-1:DW]);
  assign head_data = head_entry[DW-1:0];
  assign host_cmd  = frontend_command_t'(i_host_cmd);

  assign queue_empty  = (count == '0);
  assign head_is_read = (head_cmd.op_type == OP_READ);
  assign host_is_read = (host_cmd.op_type == OP_READ);
  assign credit_ok    = (rd_cnt < RD_LIMIT);
  // A read stuck at the head for lack of credit also holds back every write behind it.
  assign queue_valid  = !queue_empty && (!head_is_read || credit_ok);

`ifdef FRONTEND_CMD_BYPASS_EN
  assign bypass_active = queue_empty && i_host_cmd_valid && (!host_is_read || credit_ok);
`else
  assign bypass_active = 1'b0;
`endif

  assign o_host_cmd_ready         = (count != FULL_COUNT);
  assign o_frontend_command_valid = bypass_active || queue_valid;

  assign bypass_take = bypass_active && i_backend_controller_ready;
  assign pop         = queue_valid && i_backend_controller_ready;
  assign push        = i_host_cmd_valid && o_host_cmd_ready && !bypass_take;
  assign issue_read  = (pop && head_is_read) || (bypass_take && host_is_read);
  assign rd_dec      = i_backend_read_data_valid && (rd_cnt != 4'd0);

  // NOTE: outputs get their idle value first so every path assigns them and no latch is inferred.
  always_comb begin
    o_frontend_command    = '0;
    o_frontend_write_data = '0;
    if (bypass_active) begin
      o_frontend_command    = host_cmd;
      o_frontend_write_data = i_host_write_data;
    end else if (!queue_empty) begin
      o_frontend_command    = head_cmd;
      o_frontend_write_data = head_data;
    end
  end

  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rd_cnt       <= '0;
      rd_underflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      case ({issue_read, rd_dec})
        2'b10:   rd_cnt <= rd_cnt + 4'd1;
        2'b01:   rd_cnt <= rd_cnt - 4'd1;
        default: rd_cnt <= rd_cnt;
      endcase

      // Data returning with nothing outstanding is dropped but remembered until reset.
      if (i_backend_read_data_valid && (rd_cnt == 4'd0)) rd_underflow <= 1'b1;
    end
  end

  assign o_queue_count    = count;
  assign o_rd_outstanding = rd_cnt;
  assign o_rd_underflow   = rd_underflow;

endmodule

// File: tb/tb_frontend_cmd_queue.sv
// Self-checking bench for frontend_cmd_queue: constant vector table, hand sequences,
// and randomized traffic compared against a queue-based reference model.
module tb_frontend_cmd_queue;
  import frontend_command_definition_pkg::*;

  localparam int DEPTH = 8;
  localparam int MAXRD = 4;
  localparam int DW    = DQ_BITS * 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic                         clk = 1'b0;
  logic                         power_on_rst_n = 1'b0;
  logic                         i_host_cmd_valid = 1'b0;
  logic                         o_host_cmd_ready;
  logic [FRONTEND_CMD_BITS-1:0] i_host_cmd = '0;
  logic [DW-1:0]                i_host_write_data = '0;
  logic                         o_frontend_command_valid;
  logic                         i_backend_controller_ready = 1'b0;
  logic [FRONTEND_CMD_BITS-1:0] o_frontend_command;
  logic [DW-1:0]                o_frontend_write_data;
  logic                         i_backend_read_data_valid = 1'b0;
  logic [CW-1:0]                o_queue_count;
  logic [3:0]                   o_rd_outstanding;
  logic                         o_rd_underflow;

  always #5 clk = ~clk;

  frontend_cmd_queue #(.DEPTH(DEPTH), .MAX_RD_OUTSTANDING(MAXRD)) dut (
    .clk                        (clk),
    .power_on_rst_n             (power_on_rst_n),
    .i_host_cmd_valid           (i_host_cmd_valid),
    .o_host_cmd_ready           (o_host_cmd_ready),
    .i_host_cmd                 (i_host_cmd),
    .i_host_write_data          (i_host_write_data),
    .o_frontend_command_valid   (o_frontend_command_valid),
    .i_backend_controller_ready (i_backend_controller_ready),
    .o_frontend_command         (o_frontend_command),
    .o_frontend_write_data      (o_frontend_write_data),
    .i_backend_read_data_valid  (i_backend_read_data_valid),
    .o_queue_count              (o_queue_count),
    .o_rd_outstanding           (o_rd_outstanding),
    .o_rd_underflow             (o_rd_underflow)
  );

  typedef struct {
    frontend_command_t cmd;
    logic [DW-1:0]     data;
  } entry_t;

  typedef struct {
    bit       hv;
    op_type_t op;
    bit       br;
    bit       dv;
    bit       exp_valid;
    int       exp_count;
    int       exp_rd;
  } vec_t;

  entry_t model_q[$];
  int     model_rd = 0;
  bit     model_uf = 1'b0;
  int     checks   = 0;
  int     failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit hv, input op_type_t op, input bit br, input bit dv);
    frontend_command_t c;
    c.op_type = op;
    c.bank    = 3'($urandom);
    c.row     = 14'($urandom);
    c.col     = 10'($urandom);
    i_host_cmd_valid           = hv;
    i_host_cmd                 = c;
    i_host_write_data          = {$urandom, $urandom};
    i_backend_controller_ready = br;
    i_backend_read_data_valid  = dv;
  endtask

  // Compare combinational outputs with the model, clock once, then compare state.
  task automatic tick(input string tag);
    frontend_command_t hc;
    entry_t            e;
    bit                byp, qv, head_rd, pop, push, take, inc, dec, exp_valid;
    logic [63:0]       exp_cmd, exp_data;
    #1;
    hc      = frontend_command_t'(i_host_cmd);
    head_rd = (model_q.size() > 0) && (model_q[0].cmd.op_type == OP_READ);
    qv      = (model_q.size() > 0) && (!head_rd || model_rd < MAXRD);
`ifdef FRONTEND_CMD_BYPASS_EN
    byp = (model_q.size() == 0) && i_host_cmd_valid && (hc.op_type != OP_READ || model_rd < MAXRD);
`else
    byp = 1'b0;
`endif
    exp_valid = byp || qv;
    exp_cmd   = '0;
    exp_data  = '0;
    if (byp) begin
      exp_cmd  = 64'(hc);
      exp_data = 64'(i_host_write_data);
    end else if (model_q.size() > 0) begin
      exp_cmd  = 64'(model_q[0].cmd);
      exp_data = 64'(model_q[0].data);
    end
    check({tag, " valid"}, 64'(o_frontend_command_valid), 64'(exp_valid));
    check({tag, " host_ready"}, 64'(o_host_cmd_ready), 64'(model_q.size() != DEPTH));
    check({tag, " cmd"}, 64'(o_frontend_command), exp_cmd);
    check({tag, " wdata"}, 64'(o_frontend_write_data), exp_data);

    take = exp_valid && i_backend_controller_ready;
    pop  = qv && i_backend_controller_ready;
    push = i_host_cmd_valid && (model_q.size() != DEPTH) && !(byp && take);
    inc  = (pop && head_rd) || (byp && take && hc.op_type == OP_READ);
    dec  = i_backend_read_data_valid && (model_rd > 0);
    if (i_backend_read_data_valid && model_rd == 0) model_uf = 1'b1;
    e.cmd  = hc;
    e.data = i_host_write_data;

    @(posedge clk);
    #1;
    if (pop)  void'(model_q.pop_front());
    if (push) model_q.push_back(e);
    model_rd = model_rd + int'(inc) - int'(dec);
    check({tag, " count"}, 64'(o_queue_count), 64'(model_q.size()));
    check({tag, " rd_outstanding"}, 64'(o_rd_outstanding), 64'(model_rd));
    check({tag, " underflow"}, 64'(o_rd_underflow), 64'(model_uf));
  endtask

  // Asserts reset without waiting for an edge and checks outputs react asynchronously.
  task automatic do_reset();
    i_host_cmd_valid           = 1'b0;
    i_backend_controller_ready = 1'b0;
    i_backend_read_data_valid  = 1'b0;
    power_on_rst_n             = 1'b0;
    model_q.delete();
    model_rd = 0;
    model_uf = 1'b0;
    #1;
    check("reset host_ready", 64'(o_host_cmd_ready), 64'd1);
    check("reset valid", 64'(o_frontend_command_valid), 64'd0);
    check("reset cmd", 64'(o_frontend_command), 64'd0);
    check("reset wdata", 64'(o_frontend_write_data), 64'd0);
    check("reset count", 64'(o_queue_count), 64'd0);
    check("reset rd_outstanding", 64'(o_rd_outstanding), 64'd0);
    check("reset underflow", 64'(o_rd_underflow), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    power_on_rst_n = 1'b1;
  endtask

  initial begin
    vec_t tbl[17];
    // Single write, then credit limit with six reads and no early returns.
    tbl[0]  = '{1'b1, OP_WRITE, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[1]  = '{1'b0, OP_NOP,   1'b1, 1'b0, 1'b1, 0, 0};
    tbl[2]  = '{1'b1, OP_READ,  1'b1, 1'b0, 1'b0, 1, 0};
    tbl[3]  = '{1'b1, OP_READ,  1'b1, 1'b0, 1'b1, 1, 1};
    tbl[4]  = '{1'b1, OP_READ,  1'b1, 1'b0, 1'b1, 1, 2};
    tbl[5]  = '{1'b1, OP_READ,  1'b1, 1'b0, 1'b1, 1, 3};
    tbl[6]  = '{1'b1, OP_READ,  1'b1, 1'b0, 1'b1, 1, 4};
    tbl[7]  = '{1'b1, OP_READ,  1'b1, 1'b0, 1'b0, 2, 4};
    tbl[8]  = '{1'b0, OP_NOP,   1'b1, 1'b0, 1'b0, 2, 4};
    tbl[9]  = '{1'b0, OP_NOP,   1'b1, 1'b1, 1'b0, 2, 3};
    tbl[10] = '{1'b0, OP_NOP,   1'b1, 1'b0, 1'b1, 1, 4};
    tbl[11] = '{1'b0, OP_NOP,   1'b1, 1'b0, 1'b0, 1, 4};
    tbl[12] = '{1'b0, OP_NOP,   1'b1, 1'b1, 1'b0, 1, 3};
    tbl[13] = '{1'b0, OP_NOP,   1'b1, 1'b1, 1'b1, 0, 3};
    tbl[14] = '{1'b0, OP_NOP,   1'b1, 1'b1, 1'b0, 0, 2};
    tbl[15] = '{1'b0, OP_NOP,   1'b1, 1'b1, 1'b0, 0, 1};
    tbl[16] = '{1'b0, OP_NOP,   1'b1, 1'b1, 1'b0, 0, 0};

    do_reset();

`ifndef FRONTEND_CMD_BYPASS_EN
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].hv, tbl[i].op, tbl[i].br, tbl[i].dv);
      #1;
      check($sformatf("vec%0d valid", i), 64'(o_frontend_command_valid), 64'(tbl[i].exp_valid));
      tick($sformatf("vec%0d", i));
      check($sformatf("vec%0d count", i), 64'(o_queue_count), 64'(tbl[i].exp_count));
      check($sformatf("vec%0d rd", i), 64'(o_rd_outstanding), 64'(tbl[i].exp_rd));
    end
`endif

    // Simultaneous read pop and read return at rd_cnt=2.
    for (int i = 0; i < 3; i++) begin drive(1'b1, OP_READ, 1'b0, 1'b0); tick("sim_push_rd"); end
    for (int i = 0; i < 2; i++) begin drive(1'b0, OP_NOP, 1'b1, 1'b0); tick("sim_pop_rd"); end
    check("sim rd before", 64'(o_rd_outstanding), 64'd2);
    drive(1'b0, OP_NOP, 1'b1, 1'b1);
    tick("sim_pop_ret");
    check("sim rd stays 2", 64'(o_rd_outstanding), 64'd2);
    for (int i = 0; i < 2; i++) begin drive(1'b0, OP_NOP, 1'b0, 1'b1); tick("sim_ret"); end
    // Push and pop together at count=3.
    for (int i = 0; i < 3; i++) begin drive(1'b1, OP_WRITE, 1'b0, 1'b0); tick("sim_push_wr"); end
    check("sim count 3", 64'(o_queue_count), 64'd3);
    drive(1'b1, OP_WRITE, 1'b1, 1'b0);
    tick("sim_pushpop");
    check("sim count stays 3", 64'(o_queue_count), 64'd3);
    for (int i = 0; i < 4; i++) begin drive(1'b0, OP_NOP, 1'b1, 1'b0); tick("sim_drain"); end

    // Fill past full with backend stalled, then drain in order across the pointer wrap.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, OP_WRITE, 1'b0, 1'b0);
      tick("fill");
      if (i == 7) begin
        check("fill ready low", 64'(o_host_cmd_ready), 64'd0);
        check("fill count 8", 64'(o_queue_count), 64'd8);
      end
    end
    for (int i = 0; i < 8; i++) begin drive(1'b0, OP_NOP, 1'b1, 1'b0); tick("drain"); end
    check("drain count 0", 64'(o_queue_count), 64'd0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 60, op_type_t'($urandom_range(0, 3)),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 15);
      tick("rand");
    end

    // Underflow is sticky until reset.
    do_reset();
    drive(1'b0, OP_NOP, 1'b0, 1'b1);
    tick("uf_set");
    check("uf flag", 64'(o_rd_underflow), 64'd1);
    check("uf rd zero", 64'(o_rd_outstanding), 64'd0);
    for (int i = 0; i < 3; i++) begin drive(1'b0, OP_NOP, 1'b1, 1'b0); tick("uf_hold"); end
    check("uf persists", 64'(o_rd_underflow), 64'd1);
    do_reset();

    // Reset mid-cycle with five entries queued.
    for (int i = 0; i < 5; i++) begin drive(1'b1, OP_WRITE, 1'b0, 1'b0); tick("pre_rst"); end
    check("pre_rst count 5", 64'(o_queue_count), 64'd5);
    #2;
    do_reset();
    drive(1'b0, OP_NOP, 1'b1, 1'b0);
    tick("post_rst");

`ifdef FRONTEND_CMD_BYPASS_EN
    drive(1'b1, OP_WRITE, 1'b1, 1'b0);
    #1;
    check("bypass valid", 64'(o_frontend_command_valid), 64'd1);
    check("bypass cmd", 64'(o_frontend_command), 64'(i_host_cmd));
    tick("bypass");
    check("bypass count 0", 64'(o_queue_count), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
